grid_shield: RTL and testbench



---
 rtl/grid_shield_pkg.sv | 50 +++++
 rtl/grid_shield_check.sv | 35 +++
 rtl/grid_shield.sv | 115 +++++++++++
 tb/tb_grid_shield.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_shield_pkg.sv
// Shared action encoding and grid-step helper for the grid_shield safety shield.
package grid_shield_pkg;

  typedef logic [2:0] act_t;

  localparam act_t ACT_STAY  = 3'd0;
  localparam act_t ACT_UP    = 3'd1;
  localparam act_t ACT_DOWN  = 3'd2;
  localparam act_t ACT_LEFT  = 3'd3;
  localparam act_t ACT_RIGHT = 3'd4;

  // Wide enough for coordinate 16 so a step past the last column/row is visible.
  typedef logic [4:0] coord_t;

  typedef struct packed {
    logic   in_grid;
    coord_t nx;
    coord_t ny;
  } cell_t;

  function automatic cell_t next_cell(input coord_t x, input coord_t y, input act_t act,
                                      input coord_t w, input coord_t h);
    cell_t c;
    c.in_grid = 1'b1;
    c.nx      = x;
    c.ny      = y;
    case (act)
      ACT_STAY: c.in_grid = 1'b1;
      ACT_UP: begin
        c.in_grid = (y != '0);
        c.ny      = y - coord_t'(1);
      end
      ACT_DOWN: begin
        c.ny      = y + coord_t'(1);
        c.in_grid = (c.ny < h);
      end
      ACT_LEFT: begin
        c.in_grid = (x != '0);
        c.nx      = x - coord_t'(1);
      end
      ACT_RIGHT: begin
        c.nx      = x + coord_t'(1);
        c.in_grid = (c.nx < w);
      end
      default: c.in_grid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/grid_shield_check.sv
// Combinational safety check: is the action safe from (x, y), and which fallback applies.
module grid_shield_check
  import grid_shield_pkg::*;
#(
  parameter int unsigned                 GRID_W   = 4,
  parameter int unsigned                 GRID_H   = 4,
  parameter logic [GRID_W*GRID_H-1:0]    OBST_MAP = 16'h0002
) (
  input  coord_t x,
  input  coord_t y,
  input  act_t   act,
  output logic   safe,
  output act_t   fallback
);

  localparam int unsigned CELLS = GRID_W * GRID_H;

  function automatic logic is_safe(input coord_t cx, input coord_t cy, input act_t a);
    cell_t c;
    c = next_cell(cx, cy, a, coord_t'(GRID_W), coord_t'(GRID_H));
    return (a == ACT_STAY) ||
           (c.in_grid && !(|(OBST_MAP & (CELLS'(1) << (int'(c.ny) * GRID_W + int'(c.nx))))));
  endfunction

  always_comb begin
    safe     = is_safe(x, y, act);
    fallback = ACT_STAY;
    // Scan from lowest priority upward so the earliest safe candidate is left standing.
    for (int unsigned i = 4; i > 0; i--) begin
      if (act_t'(i) != act && is_safe(x, y, act_t'(i)))
        fallback = act_t'(i);
    end
  end

endmodule

// File: rtl/grid_shield.sv
// Runtime safety shield: one-entry output register, agent position tracking and intervention count.
module grid_shield
  import grid_shield_pkg::*;
#(
  parameter int unsigned                 GRID_W       = 4,
  parameter int unsigned                 GRID_H       = 4,
  parameter logic [GRID_W*GRID_H-1:0]    OBST_MAP     = 16'h0002,
  parameter int unsigned                 START_X      = 0,
  parameter int unsigned                 START_Y      = 0,
  parameter bit                          MONITOR_ONLY = 1'b0,
  parameter int unsigned                 CNT_W        = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                act_in,
  input  logic                      act_in_valid,
  output logic                      act_in_ready,
  output logic [2:0]                act_out,
  output logic                      act_out_valid,
  input  logic                      act_out_ready,
  output logic                      overridden,
  output logic [$clog2(GRID_W)-1:0] pos_x,
  output logic [$clog2(GRID_H)-1:0] pos_y,
  output logic [CNT_W-1:0]          interventions
);

  localparam int unsigned XW    = $clog2(GRID_W);
  localparam int unsigned YW    = $clog2(GRID_H);
  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam bit START_OBST = |(OBST_MAP & (CELLS'(1) << (START_Y * GRID_W + START_X)));

  logic [XW-1:0]    pos_x_q, pos_x_d;
  logic [YW-1:0]    pos_y_q, pos_y_d;
  act_t             act_out_q, act_out_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic  xfer, in_safe;
  act_t  fallback, eff_act, move_act;
  cell_t move_cell;

  grid_shield_check #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .OBST_MAP(OBST_MAP)
  ) u_check (
    .x       (coord_t'(pos_x_q)),
    .y       (coord_t'(pos_y_q)),
    .act     (act_in),
    .safe    (in_safe),
    .fallback(fallback)
  );

  always_comb begin
    act_in_ready = !valid_q || act_out_ready;
    xfer         = act_in_valid && act_in_ready;
    eff_act      = (MONITOR_ONLY || in_safe) ? act_in : fallback;
    // Monitor mode forwards unsafe raw actions but must not follow them.
    move_act     = in_safe ? act_in : (MONITOR_ONLY ? ACT_STAY : fallback);
    move_cell    = next_cell(coord_t'(pos_x_q), coord_t'(pos_y_q), move_act,
                             coord_t'(GRID_W), coord_t'(GRID_H));

    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    act_out_d = act_out_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;

    if (xfer) begin
      act_out_d = eff_act;
      ovr_d     = !in_safe;
      valid_d   = 1'b1;
      if (move_cell.in_grid && move_cell.nx < coord_t'(GRID_W) && move_cell.ny < coord_t'(GRID_H)) begin
        pos_x_d = XW'(move_cell.nx);
        pos_y_d = YW'(move_cell.ny);
      end
      if (!in_safe && cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end else if (act_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_x_q   <= XW'(START_X);
      pos_y_q   <= YW'(START_Y);
      act_out_q <= ACT_STAY;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      act_out_q <= act_out_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    assert (!START_OBST) else $error("grid_shield: start cell is marked as an obstacle");
  end

  assign act_out       = act_out_q;
  assign act_out_valid = valid_q;
  assign overridden    = ovr_q;
  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign interventions = cnt_q;

endmodule

// File: tb/tb_grid_shield.sv
// Bench for grid_shield: default, monitor-only and 2-bit-counter instances against a grid model.
module tb_grid_shield;

  logic       clock, reset;
  logic [2:0] act_in;
  logic       act_in_valid, act_out_ready;

  logic       m_rdy, m_val, m_ovr;
  logic [2:0] m_act;
  logic [1:0] m_x, m_y;
  logic [7:0] m_cnt;

  logic       n_rdy, n_val, n_ovr;
  logic [2:0] n_act;
  logic [1:0] n_x, n_y;
  logic [7:0] n_cnt;

  logic       s_rdy, s_val, s_ovr;
  logic [2:0] s_act;
  logic [1:0] s_x, s_y;
  logic [1:0] s_cnt;

  grid_shield u_main (
    .clock(clock), .reset(reset), .act_in(act_in), .act_in_valid(act_in_valid),
    .act_in_ready(m_rdy), .act_out(m_act), .act_out_valid(m_val), .act_out_ready(act_out_ready),
    .overridden(m_ovr), .pos_x(m_x), .pos_y(m_y), .interventions(m_cnt)
  );

  grid_shield #(.MONITOR_ONLY(1'b1)) u_mon (
    .clock(clock), .reset(reset), .act_in(act_in), .act_in_valid(act_in_valid),
    .act_in_ready(n_rdy), .act_out(n_act), .act_out_valid(n_val), .act_out_ready(act_out_ready),
    .overridden(n_ovr), .pos_x(n_x), .pos_y(n_y), .interventions(n_cnt)
  );

  grid_shield #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .act_in(act_in), .act_in_valid(act_in_valid),
    .act_in_ready(s_rdy), .act_out(s_act), .act_out_valid(s_val), .act_out_ready(act_out_ready),
    .overridden(s_ovr), .pos_x(s_x), .pos_y(s_y), .interventions(s_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: 4x4 grid, one obstacle at (1,0), start (0,0).
  string iname[3] = '{"main", "mon", "sat"};
  bit    mmode[3] = '{1'b0, 1'b1, 1'b0};
  int    mcmax[3] = '{255, 255, 3};
  int    mx[3], my[3], mc[3], ma[3];
  bit    mv[3], mo[3];
  bit    obst[4][4];

  function automatic bit ref_safe(input int x, input int y, input int a);
    int nx, ny;
    nx = x;
    ny = y;
    case (a)
      0: return 1'b1;
      1: ny = y - 1;
      2: ny = y + 1;
      3: nx = x - 1;
      4: nx = x + 1;
      default: return 1'b0;
    endcase
    if (nx < 0 || nx > 3 || ny < 0 || ny > 3) return 1'b0;
    return !obst[nx][ny];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0; my[i] = 0; mc[i] = 0; ma[i] = 0; mv[i] = 1'b0; mo[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit iv, input int a, input bit orr);
    for (int i = 0; i < 3; i++) begin
      bit s, found;
      int fb, step;
      if (iv && (!mv[i] || orr)) begin
        s = ref_safe(mx[i], my[i], a);
        fb = 0;
        found = 1'b0;
        for (int c = 1; c <= 4; c++)
          if (!found && c != a && ref_safe(mx[i], my[i], c)) begin
            fb = c;
            found = 1'b1;
          end
        if (mmode[i]) begin
          ma[i] = a;
          step = s ? a : 0;
        end else begin
          ma[i] = s ? a : fb;
          step = ma[i];
        end
        mo[i] = !s;
        case (step)
          1: my[i]--;
          2: my[i]++;
          3: mx[i]--;
          4: mx[i]++;
          default: ;
        endcase
        if (!s && mc[i] < mcmax[i]) mc[i]++;
        mv[i] = 1'b1;
      end else if (orr) begin
        mv[i] = 1'b0;
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic v, input logic [2:0] a, input logic o,
                          input logic [1:0] x, input logic [1:0] y, input int c);
    chk({iname[i], "_valid"}, int'(v), int'(mv[i]));
    if (mv[i]) begin
      chk({iname[i], "_act"}, int'(a), ma[i]);
      chk({iname[i], "_ovr"}, int'(o), int'(mo[i]));
    end
    chk({iname[i], "_x"}, int'(x), mx[i]);
    chk({iname[i], "_y"}, int'(y), my[i]);
    chk({iname[i], "_cnt"}, c, mc[i]);
  endtask

  task automatic check_all();
    chk_inst(0, m_val, m_act, m_ovr, m_x, m_y, int'(m_cnt));
    chk_inst(1, n_val, n_act, n_ovr, n_x, n_y, int'(n_cnt));
    chk_inst(2, s_val, s_act, s_ovr, s_x, s_y, int'(s_cnt));
  endtask

  // One clock: drive at posedge+1, check ready before the edge, outputs at posedge+1.
  task automatic cycle(input bit iv, input int a, input bit orr);
    act_in_valid  = iv;
    act_in        = 3'(a);
    act_out_ready = orr;
    #1;
    chk("main_rdy", int'(m_rdy), int'(!mv[0] || orr));
    chk("mon_rdy", int'(n_rdy), int'(!mv[1] || orr));
    chk("sat_rdy", int'(s_rdy), int'(!mv[2] || orr));
    @(posedge clock);
    model_step(iv, a, orr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    act_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_valid", int'(m_val), 0);
    chk("rst_async_x", int'(m_x), 0);
    chk("rst_async_y", int'(m_y), 0);
    chk("rst_async_cnt", int'(m_cnt), 0);
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int act;
    int ex_act;
    int ex_ovr;
    int ex_x;
    int ex_y;
    int ex_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{4, 2, 1, 0, 1, 1};
    vecs[1]  = '{4, 4, 0, 1, 1, 1};
    vecs[2]  = '{1, 2, 1, 1, 2, 2};
    vecs[3]  = '{3, 3, 0, 0, 2, 2};
    vecs[4]  = '{3, 1, 1, 0, 1, 3};
    vecs[5]  = '{6, 1, 1, 0, 0, 4};
    vecs[6]  = '{6, 2, 1, 0, 1, 5};
    vecs[7]  = '{0, 0, 0, 0, 1, 5};
    vecs[8]  = '{2, 2, 0, 0, 2, 5};
    vecs[9]  = '{2, 2, 0, 0, 3, 5};
    vecs[10] = '{2, 1, 1, 0, 2, 6};
    vecs[11] = '{4, 4, 0, 1, 2, 6};
    vecs[12] = '{4, 4, 0, 2, 2, 6};
    vecs[13] = '{4, 4, 0, 3, 2, 6};
    vecs[14] = '{4, 1, 1, 3, 1, 7};

    obst[1][0] = 1'b1;
    model_reset();
    reset = 1'b1;
    act_in = '0;
    act_in_valid = 1'b0;
    act_out_ready = 1'b1;
    #3;
    chk("reset_act", int'(m_act), 0);
    chk("reset_ovr", int'(m_ovr), 0);
    chk("reset_rdy", int'(m_rdy), 1);
    check_all();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, vecs[k].act, 1'b1);
      chk("vec_act", int'(m_act), vecs[k].ex_act);
      chk("vec_ovr", int'(m_ovr), vecs[k].ex_ovr);
      chk("vec_x", int'(m_x), vecs[k].ex_x);
      chk("vec_y", int'(m_y), vecs[k].ex_y);
      chk("vec_cnt", int'(m_cnt), vecs[k].ex_cnt);
    end
    chk("sat_hold", int'(s_cnt), 3);

    // Illegal code at the start cell, override vs monitor.
    do_reset();
    cycle(1'b1, 6, 1'b1);
    chk("ill_main_act", int'(m_act), 2);
    chk("ill_main_ovr", int'(m_ovr), 1);
    chk("ill_mon_act", int'(n_act), 6);
    chk("ill_mon_ovr", int'(n_ovr), 1);
    chk("ill_mon_x", int'(n_x), 0);
    chk("ill_mon_y", int'(n_y), 0);

    // Backpressure: output held, input blocked.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, $urandom_range(0, 7), 1'b0);
      chk("stall_rdy", int'(m_rdy), 0);
      chk("stall_act", int'(m_act), 2);
      chk("stall_valid", int'(m_val), 1);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, $urandom_range(0, 4), 1'b1);
      chk("stream_valid", int'(m_val), 1);
    end

    // Mid-stream asynchronous reset.
    chk("pre_rst_valid", int'(m_val), 1);
    do_reset();

    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
